// File: rtl/regbank_write_arbiter.sv
// rtl/regbank_write_arbiter.sv - round-robin arbiter for the register bank write port
// Optional feature macro: ZERO_REG_EN (suppresses bank writes to address 31, XZR).
module regbank_write_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_address,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          write,
    output logic [ADDR_WIDTH-1:0]         write_address,
    output logic [DATA_WIDTH-1:0]         write_data,
    output logic [2:0]                    grant_id
);

    logic [2:0]            last;
    logic                  found;
    logic [2:0]            sel_id;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_write;

    // Two passes give the rotated scan order: indices above last first, then wrap.
    always_comb begin
        req_ready = '0;
        found     = 1'b0;
        sel_id    = '0;
        sel_addr  = '0;
        sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && i > int'(last) && req_valid[i]) begin
                found        = 1'b1;
                sel_id       = 3'(i);
                sel_addr     = req_address[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data     = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                req_ready[i] = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && i <= int'(last) && req_valid[i]) begin
                found        = 1'b1;
                sel_id       = 3'(i);
                sel_addr     = req_address[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data     = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                req_ready[i] = 1'b1;
            end
        end
    end

`ifdef ZERO_REG_EN
    // XZR is handshaken like any register but never reaches the bank.
    assign sel_write = (sel_addr != ADDR_WIDTH'(31));
`else
    assign sel_write = 1'b1;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            write         <= 1'b0;
            write_address <= '0;
            write_data    <= '0;
            grant_id      <= '0;
            last          <= 3'(NUM_REQ - 1);
        end else if (found) begin
            write         <= sel_write;
            write_address <= sel_addr;
            write_data    <= sel_data;
            grant_id      <= sel_id;
            last          <= sel_id;
        end else begin
            write         <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// tb/tb_regbank_write_arbiter.sv - directed and randomized checks of regbank_write_arbiter
module tb_regbank_write_arbiter;

    localparam int N  = 2;
    localparam int AW = 5;
    localparam int DW = 64;

    logic              clock = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N*AW-1:0]   req_address;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic              write;
    logic [AW-1:0]     write_address;
    logic [DW-1:0]     write_data;
    logic [2:0]        grant_id;

    regbank_write_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_address(req_address), .req_data(req_data),
        .req_ready(req_ready), .write(write), .write_address(write_address),
        .write_data(write_data), .grant_id(grant_id)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int passes = 0;

    int          m_last;
    logic        m_write;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    int          m_gid;
    int          last_g;
    int          gcount [N];

    logic [DW-1:0] bank [32];
    always @(posedge clock) if (write) bank[write_address] <= write_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (last + k) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_last = N - 1; m_write = 1'b0; m_addr = '0; m_data = '0; m_gid = 0; last_g = -1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]          = v;
        req_address[i*AW +: AW] = a;
        req_data[i*DW +: DW]    = d;
    endtask

    // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
    task automatic step();
        int g;
        logic [N-1:0] er;
        g  = pick(req_valid, m_last);
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        #1;
        chk("req_ready", 64'(req_ready), 64'(er));
        @(posedge clock); #1;
        if (g >= 0) begin
            m_addr  = req_address[g*AW +: AW];
            m_data  = req_data[g*DW +: DW];
            m_gid   = g;
            m_last  = g;
            m_write = 1'b1;
`ifdef ZERO_REG_EN
            if (m_addr == AW'(31)) m_write = 1'b0;
`endif
            gcount[g]++;
        end else begin
            m_write = 1'b0;
        end
        last_g = g;
        chk("write", 64'(write), 64'(m_write));
        chk("write_address", 64'(write_address), 64'(m_addr));
        chk("write_data", 64'(write_data), 64'(m_data));
        chk("grant_id", 64'(grant_id), 64'(m_gid));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        reset = 1'b1; req_valid = '0; req_address = '0; req_data = '0;
        for (int i = 0; i < N; i++) gcount[i] = 0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        chk("reset write", 64'(write), 64'd0);
        chk("reset write_address", 64'(write_address), 64'd0);
        chk("reset write_data", 64'(write_data), 64'd0);
        chk("reset grant_id", 64'(grant_id), 64'd0);
        chk("reset req_ready idle", 64'(req_ready), 64'd0);
        reset = 1'b0;

        // Lone request from requester 1.
        set_req(1, 1'b1, 5'd7, 64'hDEAD);
        step();
        set_req(1, 1'b0, 5'd0, 64'h0);
        step();

        // Both requesters continuously valid after reset: 0,1,0,1.
        do_reset();
        for (int i = 0; i < N; i++) gcount[i] = 0;
        for (int c = 0; c < 4; c++) begin
            set_req(0, 1'b1, AW'(c + 8), 64'h1000 + 64'(c));
            set_req(1, 1'b1, AW'(c + 16), 64'h2000 + 64'(c));
            step();
            chk("alt grant", 64'(grant_id), 64'(c % 2));
        end
        chk("fair count req0", 64'(gcount[0]), 64'd2);
        chk("fair count req1", 64'(gcount[1]), 64'd2);

        // Same address from both: last grant wins in the bank.
        set_req(0, 1'b1, 5'd3, 64'hAAAA_0000_0000_000A);
        set_req(1, 1'b1, 5'd3, 64'hBBBB_0000_0000_000B);
        step();
        set_req(0, 1'b0, 5'd0, 64'h0);
        step();
        set_req(1, 1'b0, 5'd0, 64'h0);
        step();
        chk("bank reg3 last wins", bank[3], 64'hBBBB_0000_0000_000B);

        // Address 31 request.
        set_req(0, 1'b1, 5'd31, 64'h3131);
        step();
`ifdef ZERO_REG_EN
        chk("xzr write suppressed", 64'(write), 64'd0);
`else
        chk("xzr write normal", 64'(write), 64'd1);
`endif
        set_req(0, 1'b0, 5'd0, 64'h0);

        // Idle cycles, then a single request granted immediately.
        repeat (3) step();
        set_req(0, 1'b1, 5'd9, 64'h99);
        step();
        chk("after idle grant", 64'(grant_id), 64'd0);
        set_req(0, 1'b0, 5'd0, 64'h0);
        step();

        // Reset asserted mid-transfer.
        set_req(0, 1'b1, 5'd4, 64'h44);
        set_req(1, 1'b1, 5'd5, 64'h55);
        step();
        step();
        chk("pre-reset write", 64'(write), 64'd1);
        reset = 1'b1;
        #1;
        chk("async reset write", 64'(write), 64'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        model_reset();
        step();
        chk("post-reset grant", 64'(grant_id), 64'd0);

        // Randomized traffic; a pending request is held until granted.
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || i == last_g)
                    set_req(i, 1'(($urandom % 3) != 0), AW'($urandom % 32), {$urandom, $urandom});
            end
            step();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
